// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: the imem req/ack channel plus the decoded instruction handed to the datapath.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [5:0]        op;
  logic [5:0]        funct;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus4;
  logic              instr_ready;
  logic              branch_taken;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, op, funct, pc_out, pc_plus4,
    input  imem_ack, imem_rdata, instr_ready, branch_taken
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, op, funct, pc_out, pc_plus4,
    output imem_ack, imem_rdata, instr_ready, branch_taken
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches over req/ack into the IR, and advances to PC+4 or the beq
// target when the datapath retires the held instruction.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               rst_n,
    instr_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_ir;
    logic [31:0]       r_ir;
    logic              w_req;
    logic              w_valid;
    logic              w_load;
    logic              w_retire;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_offset;
    logic [ADDR_W-1:0] w_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            ST_RST: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_req = 1'b1;
                if (bus.imem_ack) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_valid = 1'b1;
                if (bus.instr_ready) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_RST;
            end
        endcase
    end

    assign w_load     = (r_state == ST_FETCH) && bus.imem_ack;
    assign w_retire   = (r_state == ST_HOLD) && bus.instr_ready;
    // pc_plus4 and the branch target are relative to the PC captured with the IR, not the live PC.
    assign w_pc_plus4 = r_pc_ir + ADDR_W'(4);
    assign w_offset   = {{(ADDR_W-18){r_ir[15]}}, r_ir[15:0], 2'b00};
    assign w_target   = w_pc_plus4 + w_offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_pc_ir <= RESET_PC;
            r_ir    <= '0;
        end else begin
            if (w_load) begin
                r_ir    <= bus.imem_rdata;
                r_pc_ir <= r_pc;
            end
            if (w_retire) begin
                r_pc <= bus.branch_taken ? w_target : w_pc_plus4;
            end
        end
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = w_valid;
    assign bus.instr       = r_ir;
    assign bus.op          = r_ir[31:26];
    assign bus.funct       = r_ir[5:0];
    assign bus.pc_out      = r_pc_ir;
    assign bus.pc_plus4    = w_pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed program-flow cases followed by randomized fetch/retire
// traffic, checked against a transaction-level PC/IR reference model.
module tb_instr_fetch_unit;

    logic clk;
    logic rst_n;

    int unsigned n_cmp;
    int unsigned n_err;

    logic [31:0] m_pc;
    logic [31:0] m_ir;

    instr_fetch_unit_if #(.ADDR_W(32)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference next-PC: plain signed arithmetic on the immediate, 32-bit wrap.
    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] ir,
                                            input logic taken);
        int imm;
        imm = int'($signed(ir[15:0]));
        if (taken) return pc + 32'd4 + 32'(imm * 4);
        return pc + 32'd4;
    endfunction

    task automatic do_fetch(input logic [31:0] word, input int unsigned waits);
        int unsigned n;
        n = 0;
        while (!bus.imem_req && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 32'(bus.imem_req), 32'd1);
        chk("fetch_addr", bus.imem_addr, m_pc);
        for (int unsigned w = 0; w < waits; w++) begin
            bus.imem_ack     = 1'b0;
            bus.imem_rdata   = $urandom;
            bus.instr_ready  = 1'($urandom_range(0, 1));
            bus.branch_taken = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("req_held", 32'(bus.imem_req), 32'd1);
            chk("addr_stable", bus.imem_addr, m_pc);
            chk("valid_low_fetch", 32'(bus.instr_valid), 32'd0);
        end
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = word;
        bus.instr_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = $urandom;
        bus.instr_ready  = 1'b0;
        bus.branch_taken = 1'b0;
        m_ir = word;
        chk("valid_hold", 32'(bus.instr_valid), 32'd1);
        chk("req_low_hold", 32'(bus.imem_req), 32'd0);
        chk("instr", bus.instr, word);
        chk("op", 32'(bus.op), 32'(word[31:26]));
        chk("funct", 32'(bus.funct), 32'(word[5:0]));
        chk("pc_out", bus.pc_out, m_pc);
        chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    endtask

    task automatic do_retire(input int unsigned stall, input logic taken);
        logic [31:0] old_pc;
        old_pc = m_pc;
        for (int unsigned s = 0; s < stall; s++) begin
            bus.instr_ready  = 1'b0;
            bus.branch_taken = 1'($urandom_range(0, 1));
            bus.imem_ack     = 1'($urandom_range(0, 1));
            bus.imem_rdata   = $urandom;
            @(negedge clk);
            chk("valid_stall", 32'(bus.instr_valid), 32'd1);
            chk("instr_stall", bus.instr, m_ir);
            chk("req_low_stall", 32'(bus.imem_req), 32'd0);
            chk("addr_stall", bus.imem_addr, old_pc);
        end
        bus.imem_ack     = 1'b0;
        bus.instr_ready  = 1'b1;
        bus.branch_taken = taken;
        @(negedge clk);
        bus.instr_ready  = 1'b0;
        bus.branch_taken = 1'b0;
        m_pc = next_pc(old_pc, m_ir, taken);
        chk("req_after_retire", 32'(bus.imem_req), 32'd1);
        chk("valid_after_retire", 32'(bus.instr_valid), 32'd0);
        chk("next_addr", bus.imem_addr, m_pc);
        chk("pc_out_kept", bus.pc_out, old_pc);
    endtask

    function automatic logic [31:0] mk_word(input logic [5:0] op, input logic [15:0] imm);
        logic [31:0] w;
        w = $urandom;
        w[31:26] = op;
        w[15:0]  = imm;
        return w;
    endfunction

    initial begin
        logic [31:0] w;
        n_cmp = 0;
        n_err = 0;
        m_pc  = 32'h0;
        m_ir  = 32'h0;
        rst_n            = 1'b0;
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = 32'h0;
        bus.instr_ready  = 1'b0;
        bus.branch_taken = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_pc_out", bus.pc_out, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);

        // Release mid-cycle: this cycle is spent in RST, the request appears in the next one.
        rst_n = 1'b1;
        #1;
        chk("req_in_rst_cycle", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        chk("req_cycle2", 32'(bus.imem_req), 32'd1);
        chk("req_cycle2_addr", bus.imem_addr, 32'h0);

        for (int i = 0; i < 3; i++) begin
            do_fetch(mk_word(6'h23, 16'($urandom)), 0);
            do_retire(0, 1'b0);
        end
        chk("after_lw_pc", m_pc, 32'hC);

        do_fetch(mk_word(6'h00, 16'($urandom)), 1);
        do_retire(0, 1'b0);
        do_fetch(mk_word(6'h04, 16'hFFFC), 0);
        do_retire(0, 1'b1);
        chk("beq_back_addr", bus.imem_addr, 32'h4);
        do_fetch(mk_word(6'h04, 16'h0002), 0);
        do_retire(1, 1'b1);
        chk("beq_fwd_to_10", bus.imem_addr, 32'h10);
        do_fetch(mk_word(6'h04, 16'h0002), 0);
        do_retire(0, 1'b1);
        chk("beq_fwd_addr", bus.imem_addr, 32'h1C);

        do_fetch(mk_word(6'h23, 16'($urandom)), 3);
        do_retire(4, 1'b0);
        chk("stall_next_addr", bus.imem_addr, 32'h20);

        do_fetch(mk_word(6'h04, 16'hFFF6), 0);
        do_retire(0, 1'b1);
        chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        do_fetch(mk_word(6'h23, 16'($urandom)), 0);
        chk("top_pc_plus4_wrap", bus.pc_plus4, 32'h0);
        do_retire(0, 1'b0);
        chk("wrap_addr", bus.imem_addr, 32'h0);

        for (int i = 0; i < 60; i++) begin
            do_fetch($urandom, $urandom_range(0, 3));
            do_retire($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Make sure reset is applied from a non-reset PC.
        if (m_pc == 32'h0) begin
            do_fetch(mk_word(6'h23, 16'h0), 0);
            do_retire(0, 1'b0);
        end
        w = $urandom;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = w;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(bus.imem_req), 32'd0);
        chk("arst_valid", 32'(bus.instr_valid), 32'd0);
        chk("arst_addr", bus.imem_addr, 32'h0);
        chk("arst_instr", bus.instr, 32'h0);
        @(posedge clk);
        #1;
        chk("arst_ack_ignored", bus.instr, 32'h0);
        chk("arst_valid_edge", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        rst_n = 1'b1;
        m_pc = 32'h0;
        @(negedge clk);
        chk("refetch_req", 32'(bus.imem_req), 32'd1);
        do_fetch(mk_word(6'h23, 16'($urandom)), 0);
        do_retire(0, 1'b0);
        chk("refetch_next", bus.imem_addr, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
